// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage sitting between the EX/MEM
// and MEM/WB registers. Loads and stores go to a single-port data memory over
// a req/ack handshake; the upstream pipeline is stalled while a request is
// outstanding. Non-memory instructions pass straight through in one cycle.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   When defined, a memory op whose byte address is not word aligned issues
//   no request. It is retired the next cycle with RegWrite cleared, and
//   o_misalignErr pulses for that one cycle.
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int WR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_validIn,
  input  logic              i_memReadIn,
  input  logic              i_memWriteIn,
  input  logic              i_regWriteIn,
  input  logic [WR_W-1:0]   i_writeRegisterIn,
  input  logic [DATA_W-1:0] i_aluResultIn,
  input  logic [DATA_W-1:0] i_storeDataIn,
  output logic              o_stallOut,
  output logic              o_memReq,
  output logic              o_memWe,
  output logic [DATA_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWData,
  input  logic              i_memAck,
  input  logic [DATA_W-1:0] i_memRData,
  output logic              o_validOut,
  output logic              o_regWriteOut,
  output logic [WR_W-1:0]   o_writeRegisterOut,
  output logic [DATA_W-1:0] o_aluResultOut
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              o_misalignErr
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stateT;

  stateT             r_state;
  stateT             w_nextState;
  logic              r_capRegWrite;
  logic [WR_W-1:0]   r_capWriteReg;
  logic              w_memOp;
  logic              w_misalign;
  logic              w_issue;

  // A real instruction that touches memory; a simultaneous read+write is a store
  assign w_memOp = i_validIn & (i_memReadIn | i_memWriteIn);

`ifdef MEM_ALIGN_CHECK_EN
  // Word accesses need the two low address bits clear
  assign w_misalign = w_memOp & (i_aluResultIn[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Only aligned memory ops in IDLE actually launch a request
  assign w_issue = w_memOp & ~w_misalign;

  // Next-state and stall: stall while a request is being launched or is still
  // waiting, and let upstream advance in the ack cycle
  always_comb begin
    w_nextState = r_state;
    o_stallOut  = 1'b0;
    if (i_reset) begin
      w_nextState = IDLE;
      o_stallOut  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            w_nextState = BUSY;
            o_stallOut  = 1'b1;
          end
        end
        BUSY: begin
          o_stallOut = ~i_memAck;
          if (i_memAck) begin
            w_nextState = IDLE;
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Memory request, captured write-back fields and MEM/WB outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_memReq           <= 1'b0;
      o_memWe            <= 1'b0;
      o_memAddr          <= '0;
      o_memWData         <= '0;
      r_capRegWrite      <= 1'b0;
      r_capWriteReg      <= '0;
      o_validOut         <= 1'b0;
      o_regWriteOut      <= 1'b0;
      o_writeRegisterOut <= '0;
      o_aluResultOut     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            o_memReq      <= 1'b1;
            o_memWe       <= i_memWriteIn;
            o_memAddr     <= i_aluResultIn;
            o_memWData    <= i_storeDataIn;
            r_capRegWrite <= i_regWriteIn;
            r_capWriteReg <= i_writeRegisterIn;
            o_validOut    <= 1'b0;
            o_regWriteOut <= 1'b0;
          end else if (w_misalign) begin
            o_validOut         <= 1'b1;
            o_regWriteOut      <= 1'b0;
            o_writeRegisterOut <= i_writeRegisterIn;
            o_aluResultOut     <= i_aluResultIn;
          end else if (i_validIn) begin
            o_validOut         <= 1'b1;
            o_regWriteOut      <= i_regWriteIn;
            o_writeRegisterOut <= i_writeRegisterIn;
            o_aluResultOut     <= i_aluResultIn;
          end else begin
            o_validOut    <= 1'b0;
            o_regWriteOut <= 1'b0;
          end
        end
        BUSY: begin
          if (i_memAck) begin
            o_memReq           <= 1'b0;
            o_validOut         <= 1'b1;
            o_writeRegisterOut <= r_capWriteReg;
            if (o_memWe) begin
              o_regWriteOut  <= 1'b0;
              o_aluResultOut <= o_memAddr;
            end else begin
              o_regWriteOut  <= r_capRegWrite;
              o_aluResultOut <= i_memRData;
            end
          end else begin
            o_validOut    <= 1'b0;
            o_regWriteOut <= 1'b0;
          end
        end
        default: begin
          o_memReq   <= 1'b0;
          o_validOut <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // One-cycle error pulse for a misaligned access retired from IDLE
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_misalignErr <= 1'b0;
    end else begin
      o_misalignErr <= (r_state == IDLE) & w_misalign;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed vectors drive the stage, expected
// write-back records are queued as each instruction is issued, and a monitor
// pops and compares them whenever the stage presents o_validOut.
module tb_mem_access_stage;

  localparam int DATA_W = 32;
  localparam int WR_W   = 32;

  typedef struct packed {
    logic              regWrite;
    logic [WR_W-1:0]   writeReg;
    logic [DATA_W-1:0] result;
  } wbT;

  logic              clk;
  logic              reset;
  logic              validIn;
  logic              memReadIn;
  logic              memWriteIn;
  logic              regWriteIn;
  logic [WR_W-1:0]   writeRegisterIn;
  logic [DATA_W-1:0] aluResultIn;
  logic [DATA_W-1:0] storeDataIn;
  logic              stallOut;
  logic              memReq;
  logic              memWe;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic              memAck;
  logic [DATA_W-1:0] memRData;
  logic              validOut;
  logic              regWriteOut;
  logic [WR_W-1:0]   writeRegisterOut;
  logic [DATA_W-1:0] aluResultOut;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misalignErr;
`endif

  int checks = 0;
  int errors = 0;
  wbT expQ[$];

  mem_access_stage #(.DATA_W(DATA_W), .WR_W(WR_W)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_validIn          (validIn),
    .i_memReadIn        (memReadIn),
    .i_memWriteIn       (memWriteIn),
    .i_regWriteIn       (regWriteIn),
    .i_writeRegisterIn  (writeRegisterIn),
    .i_aluResultIn      (aluResultIn),
    .i_storeDataIn      (storeDataIn),
    .o_stallOut         (stallOut),
    .o_memReq           (memReq),
    .o_memWe            (memWe),
    .o_memAddr          (memAddr),
    .o_memWData         (memWData),
    .i_memAck           (memAck),
    .i_memRData         (memRData),
    .o_validOut         (validOut),
    .o_regWriteOut      (regWriteOut),
    .o_writeRegisterOut (writeRegisterOut),
    .o_aluResultOut     (aluResultOut)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .o_misalignErr      (misalignErr)
`endif
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one full set of upstream and memory inputs
  task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic rw,
                               input logic [WR_W-1:0] wreg, input logic [DATA_W-1:0] alu,
                               input logic [DATA_W-1:0] sd, input logic ack,
                               input logic [DATA_W-1:0] rdata);
    validIn         = v;
    memReadIn       = rd;
    memWriteIn      = wr;
    regWriteIn      = rw;
    writeRegisterIn = wreg;
    aluResultIn     = alu;
    storeDataIn     = sd;
    memAck          = ack;
    memRData        = rdata;
  endtask

  task automatic pushExp(input logic rw, input logic [WR_W-1:0] wreg, input logic [DATA_W-1:0] res);
    wbT e;
    e.regWrite = rw;
    e.writeReg = wreg;
    e.result   = res;
    expQ.push_back(e);
  endtask

  // Monitor: every presented write-back must match the oldest expected record
  always @(negedge clk) begin
    if (!reset && validOut) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL wb_unexpected: got wreg 0x%0h result 0x%0h expected no write-back at %0t",
                 writeRegisterOut, aluResultOut, $time);
      end else begin
        wbT e;
        e = expQ.pop_front();
        checkOutput("wb_regWrite", {63'd0, regWriteOut}, {63'd0, e.regWrite});
        checkOutput("wb_writeReg", {32'd0, writeRegisterOut}, {32'd0, e.writeReg});
        checkOutput("wb_result", {32'd0, aluResultOut}, {32'd0, e.result});
      end
    end
  end

  // Directed sequence
  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_validOut", {63'd0, validOut}, 64'd0);
    checkOutput("rst_memReq", {63'd0, memReq}, 64'd0);
    checkOutput("rst_stall", {63'd0, stallOut}, 64'd0);
    checkOutput("rst_memAddr", {32'd0, memAddr}, 64'd0);
    checkOutput("rst_result", {32'd0, aluResultOut}, 64'd0);
    reset = 1'b0;

    // ALU op passes through in one cycle without stalling
    @(posedge clk); #1;
    applyStimulus(1, 0, 0, 1, 5, 32'h1234, 0, 0, 0);
    pushExp(1'b1, 5, 32'h1234);
    @(negedge clk);
    checkOutput("alu_stall", {63'd0, stallOut}, 64'd0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("alu_validOut", {63'd0, validOut}, 64'd1);

    // Load at 0x40, three waiting cycles then ack with 0xDEADBEEF
    @(posedge clk); #1;
    applyStimulus(1, 1, 0, 1, 7, 32'h40, 0, 0, 0);
    pushExp(1'b1, 7, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("bubble_validOut", {63'd0, validOut}, 64'd0);
    checkOutput("ld_stall_issue", {63'd0, stallOut}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("ld_memReq", {63'd0, memReq}, 64'd1);
      checkOutput("ld_memWe", {63'd0, memWe}, 64'd0);
      checkOutput("ld_memAddr", {32'd0, memAddr}, 64'h40);
      checkOutput("ld_stall_wait", {63'd0, stallOut}, 64'd1);
      checkOutput("ld_validOut_wait", {63'd0, validOut}, 64'd0);
    end
    @(posedge clk); #1;
    memAck   = 1'b1;
    memRData = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("ld_stall_ack", {63'd0, stallOut}, 64'd0);
    checkOutput("ld_memReq_ack", {63'd0, memReq}, 64'd1);

    // ALU op immediately after the load ack
    @(posedge clk); #1;
    applyStimulus(1, 0, 0, 1, 9, 32'h55, 0, 0, 0);
    pushExp(1'b1, 9, 32'h55);
    @(negedge clk);
    checkOutput("b2b_stall", {63'd0, stallOut}, 64'd0);
    checkOutput("b2b_memReq", {63'd0, memReq}, 64'd0);

    // Store 0xCAFEF00D to 0x80 with immediate ack
    @(posedge clk); #1;
    applyStimulus(1, 0, 1, 1, 3, 32'h80, 32'hCAFEF00D, 0, 0);
    pushExp(1'b0, 3, 32'h80);
    @(negedge clk);
    checkOutput("st_stall_issue", {63'd0, stallOut}, 64'd1);
    @(posedge clk); #1;
    memAck = 1'b1;
    @(negedge clk);
    checkOutput("st_memReq", {63'd0, memReq}, 64'd1);
    checkOutput("st_memWe", {63'd0, memWe}, 64'd1);
    checkOutput("st_memWData", {32'd0, memWData}, 64'hCAFEF00D);
    checkOutput("st_memAddr", {32'd0, memAddr}, 64'h80);
    checkOutput("st_stall_ack", {63'd0, stallOut}, 64'd0);

    // Read and write together: the store wins
    @(posedge clk); #1;
    applyStimulus(1, 1, 1, 1, 4, 32'h90, 32'h11, 0, 0);
    pushExp(1'b0, 4, 32'h90);
    @(negedge clk);
    checkOutput("rw_memReq_done", {63'd0, memReq}, 64'd0);
    @(posedge clk); #1;
    memAck   = 1'b1;
    memRData = 32'hBAD0BAD0;
    @(negedge clk);
    checkOutput("rw_memWe", {63'd0, memWe}, 64'd1);
    checkOutput("rw_memWData", {32'd0, memWData}, 64'h11);

    // Reset during an outstanding load, with ack in the reset cycle
    @(posedge clk); #1;
    applyStimulus(1, 1, 0, 1, 6, 32'h100, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_ld_stall", {63'd0, stallOut}, 64'd1);
    @(posedge clk); #1;
    reset    = 1'b1;
    memAck   = 1'b1;
    memRData = 32'h12345678;
    @(negedge clk);
    checkOutput("rst_mid_stall", {63'd0, stallOut}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    @(negedge clk);
    checkOutput("rst_mid_memReq", {63'd0, memReq}, 64'd0);
    checkOutput("rst_mid_validOut", {63'd0, validOut}, 64'd0);
    @(posedge clk); #1;
    memAck = 1'b0;
    @(negedge clk);
    checkOutput("idle_ack_validOut", {63'd0, validOut}, 64'd0);
    checkOutput("idle_ack_memReq", {63'd0, memReq}, 64'd0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load at 0x42 retires without a request
    @(posedge clk); #1;
    applyStimulus(1, 1, 0, 1, 8, 32'h42, 0, 0, 0);
    pushExp(1'b0, 8, 32'h42);
    @(negedge clk);
    checkOutput("mis_stall", {63'd0, stallOut}, 64'd0);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("mis_memReq", {63'd0, memReq}, 64'd0);
    checkOutput("mis_err", {63'd0, misalignErr}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mis_err_clear", {63'd0, misalignErr}, 64'd0);
`endif

    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
